// File: rtl/riscuinho_pkg.sv
// Shared RV32I core definitions: word size, canonical NOP, and the
// fetch-stage state encoding and queue entry layout.
package riscuinho_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FLUSH,
    S_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// decoder valid/ready channel, and the redirect/fault side-band.
interface instruction_fetch_if;
  import riscuinho_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_fault;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr, instr_pc, instr_valid,
    input  instr_ready,
    input  redirect, redirect_pc,
    output fetch_fault
  );

  // Memory / decoder / branch-unit side
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr, instr_pc, instr_valid,
    output instr_ready,
    output redirect, redirect_pc,
    input  fetch_fault
  );

endinterface

// File: rtl/instruction_fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs between the memory response and the
// decoder. Flush empties it; stored words are not cleared, only forgotten.
module fetch_queue
  import riscuinho_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I instruction fetch: owns the fetch PC, keeps at most one memory
// request in flight, buffers responses in a 2-entry queue and hands them
// to the decoder. Redirects flush everything and may raise a sticky fault.
module instruction_fetch
  import riscuinho_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  instruction_fetch_if.master bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            running;
  logic            fault;

  fetch_entry_t    head;
  logic [1:0]      count;
  logic            req;
  logic            push;
  logic            pop;
  logic            outstanding;
  logic            target_bad;

  // Request depends only on registered state, so no input reaches it combinationally
  assign req = running && (state == S_REQ) && (count <= 2'd1);

  assign bus.imem_req    = req;
  assign bus.imem_addr   = {fetch_pc[XLEN-1:2], 2'b00};
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.fetch_fault = fault;

  assign push       = (state == S_WAIT) && bus.imem_rvalid && !bus.redirect;
  assign pop        = (count != 2'd0) && bus.instr_ready;
  assign target_bad = is_misaligned(bus.redirect_pc);

  // A request is still in flight after this cycle if its response has not arrived
  // yet, or if one is being granted right now
  always_comb begin
    outstanding = 1'b0;
    case (state)
      S_WAIT, S_FLUSH: outstanding = !bus.imem_rvalid;
      S_REQ:           outstanding = req && bus.imem_gnt;
      default:         outstanding = 1'b0;
    endcase
  end

  // Fetch FSM: redirect takes priority over normal request/response sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      running  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      running <= 1'b1;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
        fault    <= target_bad;
        if (outstanding)     state <= S_FLUSH;
        else if (target_bad) state <= S_FAULT;
        else                 state <= S_REQ;
      end else begin
        case (state)
          S_REQ: begin
            if (req && bus.imem_gnt) begin
              req_pc   <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd4;
              state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.imem_rvalid) state <= S_REQ;
          end
          S_FLUSH: begin
            // A misaligned redirect parks here until the stale response drains
            if (bus.imem_rvalid) state <= fault ? S_FAULT : S_REQ;
          end
          default: state <= S_FAULT;
        endcase
      end
    end
  end

  fetch_queue #(
    .RESET_PC(RESET_PC)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{pc: req_pc, instr: bus.imem_rdata}),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a latency-configurable memory model
// answers each grant with word(addr) = addr + 0x1000_0000, and a monitor logs
// every decoder handshake; the main sequence checks the log and outputs.
module tb_instruction_fetch;
  import riscuinho_pkg::*;

  logic clk;
  logic reset;
  logic gnt_en;
  int   lat_k;
  int   tests;
  int   fails;
  int   cyc;
  int   overflow;

  logic [63:0] got_q [$];
  int          stamp_q [$];

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_gnt = bus.imem_req & gnt_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  // Memory model: response k cycles after the grant cycle, in order
  logic        pend;
  int          left;
  logic [31:0] paddr;
  always @(posedge clk) begin
    logic        g;
    logic [31:0] a;
    logic        rs;
    g  = bus.imem_req && bus.imem_gnt;
    a  = bus.imem_addr;
    rs = reset;
    #1;
    bus.imem_rvalid = 1'b0;
    if (rs) begin
      pend = 1'b0;
    end else if (g) begin
      paddr = a;
      if (lat_k == 1) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word(a);
      end else begin
        pend = 1'b1;
        left = lat_k - 1;
      end
    end else if (pend) begin
      left = left - 1;
      if (left == 0) begin
        pend            = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word(paddr);
      end
    end
  end

  // Handshake monitor and queue-overflow watch
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      got_q.push_back({bus.instr_pc, bus.instr});
      stamp_q.push_back(cyc);
    end
    if (!reset && dut.push && !dut.pop && dut.u_queue.count == 2'd2 && !bus.redirect)
      overflow = overflow + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in the first cycle after reset release
  task automatic do_reset();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();
    got_q.delete();
    stamp_q.delete();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_got(input int n, input string tag);
    int b;
    b = 0;
    while (got_q.size() < n && b < 60) begin
      tick();
      b++;
    end
    chk(tag, 32'(got_q.size() >= n), 32'd1);
  endtask

  logic [63:0] e;
  int          rel;

  initial begin
    tests = 0; fails = 0; cyc = 0; overflow = 0;
    pend = 1'b0; left = 0; paddr = '0;
    gnt_en = 1'b1; lat_k = 1;
    bus.instr_ready = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    reset = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_req",   32'(bus.imem_req),    32'd0);
    chk("rst_addr",  bus.imem_addr,        32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr,            32'h0000_0013);
    chk("rst_pc",    bus.instr_pc,         32'h0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);

    // Streaming, k=1, decoder always ready
    do_reset();
    rel = cyc;
    chk("t1_first_req",  32'(bus.imem_req), 32'd1);
    chk("t1_first_addr", bus.imem_addr,     32'h0);
    wait_got(3, "t1_timeout");
    e = got_q[0]; chk("t1_pc0", e[63:32], 32'h0); chk("t1_i0", e[31:0], 32'h1000_0000);
    e = got_q[1]; chk("t1_pc1", e[63:32], 32'h4); chk("t1_i1", e[31:0], 32'h1000_0004);
    e = got_q[2]; chk("t1_pc2", e[63:32], 32'h8); chk("t1_i2", e[31:0], 32'h1000_0008);
    // Grant in cycle 0, response cycle 1, valid cycle 2: its handshake edge is 3 edges on
    chk("t1_latency", 32'(stamp_q[0] - rel),        32'd3);
    chk("t1_gap01",   32'(stamp_q[1] - stamp_q[0]), 32'd2);
    chk("t1_gap12",   32'(stamp_q[2] - stamp_q[1]), 32'd2);

    // Back-pressure: queue fills, requests stop, then drain in order
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    chk("t2_full_req",   32'(bus.imem_req),    32'd0);
    chk("t2_full_addr",  bus.imem_addr,        32'h8);
    chk("t2_full_valid", 32'(bus.instr_valid), 32'd1);
    chk("t2_head_pc",    bus.instr_pc,         32'h0);
    chk("t2_head_instr", bus.instr,            32'h1000_0000);
    repeat (3) tick();
    chk("t2_stable_pc",  bus.instr_pc,         32'h0);
    chk("t2_no_pop",     32'(got_q.size()),    32'd0);
    bus.instr_ready = 1'b1;
    tick();
    chk("t2_resume_req",  32'(bus.imem_req), 32'd1);
    chk("t2_resume_addr", bus.imem_addr,     32'h8);
    wait_got(3, "t2_timeout");
    e = got_q[0]; chk("t2_pc0", e[63:32], 32'h0);
    e = got_q[1]; chk("t2_pc1", e[63:32], 32'h4);
    e = got_q[2]; chk("t2_pc2", e[63:32], 32'h8);

    // Redirect while waiting on a slow (k=3) response
    lat_k = 3;
    do_reset();
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    chk("t3_valid_after", 32'(bus.instr_valid), 32'd0);
    chk("t3_req_after",   32'(bus.imem_req),    32'd0);
    wait_got(2, "t3_timeout");
    e = got_q[0]; chk("t3_pc0", e[63:32], 32'h100); chk("t3_i0", e[31:0], 32'h1000_0100);
    e = got_q[1]; chk("t3_pc1", e[63:32], 32'h104);

    // Redirect coincident with a grant
    lat_k = 1;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
    tick();
    bus.redirect = 1'b0;
    chk("t4a_req",   32'(bus.imem_req),    32'd0);
    chk("t4a_valid", 32'(bus.instr_valid), 32'd0);
    wait_got(1, "t4a_timeout");
    e = got_q[0]; chk("t4a_pc0", e[63:32], 32'h300); chk("t4a_i0", e[31:0], 32'h1000_0300);

    // Redirect coincident with a response
    do_reset();
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h400;
    tick();
    bus.redirect = 1'b0;
    chk("t4b_valid", 32'(bus.instr_valid), 32'd0);
    chk("t4b_req",   32'(bus.imem_req),    32'd1);
    chk("t4b_addr",  bus.imem_addr,        32'h400);
    wait_got(1, "t4b_timeout");
    e = got_q[0]; chk("t4b_pc0", e[63:32], 32'h400);

    // Misaligned redirect: sticky fault, no requests, cleared by next redirect
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h102;
    tick();
    bus.redirect = 1'b0;
    chk("t5_fault_set", 32'(bus.fetch_fault), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_req", 32'(bus.imem_req), 32'd0);
    end
    chk("t5_fault_hold", 32'(bus.fetch_fault), 32'd1);
    chk("t5_valid",      32'(bus.instr_valid), 32'd0);
    chk("t5_addr",       bus.imem_addr,        32'h100);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    chk("t5_fault_clr", 32'(bus.fetch_fault), 32'd0);
    chk("t5_req",       32'(bus.imem_req),    32'd1);
    chk("t5_req_addr",  bus.imem_addr,        32'h200);
    wait_got(1, "t5_timeout");
    e = got_q[0]; chk("t5_pc0", e[63:32], 32'h200);

    // PC wrap from the top of the address space
    gnt_en = 1'b0;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    gnt_en = 1'b1;
    chk("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    wait_got(2, "t6_timeout");
    e = got_q[0]; chk("t6_pc0", e[63:32], 32'hFFFF_FFFC); chk("t6_i0", e[31:0], 32'h0FFF_FFFC);
    e = got_q[1]; chk("t6_pc1", e[63:32], 32'h0);

    chk("queue_overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the RV32I core: owns the fetch PC, issues word requests to instruction memory, buffers returned words in a 2-entry queue, and presents `{instr, instr_pc}` to `InstructionDecoderRV32I` under a valid/ready handshake. Branch and jump resolution downstream redirects it through `redirect`/`redirect_pc`, which flushes all in-flight and buffered instructions.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  request valid; function of registered state only.
- `imem_addr`  out  32  word address of request; bits [1:0] always 0.
- `imem_gnt`  in  1  memory accepts request this cycle (only meaningful with `imem_req`).
- `imem_rvalid`  in  1  read data valid; arrives ≥1 cycle after grant, in order.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  instruction to decoder (queue head).
- `instr_pc`  out  32  address of `instr`.
- `instr_valid`  out  1  queue non-empty.
- `instr_ready`  in  1  decoder consumes head when `instr_valid && instr_ready`.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address.
- `fetch_fault`  out  1  sticky: misaligned redirect target.

## Operation
- FSM states: `S_REQ` (may issue), `S_WAIT` (one request outstanding), `S_FLUSH` (stale request outstanding, response discarded), `S_FAULT`.
- At most one outstanding request.
- `S_REQ`: `imem_req = (count <= 1)`; `imem_addr = fetch_pc`. On `imem_gnt`: `fetch_pc <= fetch_pc + 4` (mod 2^32), go `S_WAIT`.
- `S_WAIT`: on `imem_rvalid`, push `{imem_rdata, req_pc}` into queue, go `S_REQ`. `req_pc` = address latched at grant.
- `S_FLUSH`: on `imem_rvalid`, drop data, go `S_REQ`.
- Queue: 2 entries, FIFO order; pop on consumer handshake. Push and pop in same cycle allowed. Space is guaranteed because issue requires `count <= 1`; overflow is a design error (bench asserts never).
- Redirect (highest priority, any state): queue cleared, `fetch_pc <= redirect_pc`, `fetch_fault <= 0`. Next state: `S_FLUSH` if a request is outstanding after this cycle (state `S_WAIT` without `imem_rvalid`, `S_FLUSH` without `imem_rvalid`, or `S_REQ` with `imem_gnt`); otherwise `S_REQ`. Response arriving in redirect cycle is dropped. Handshake in redirect cycle counts as consumed.
- Misaligned target (`redirect_pc[1:0] != 0`): `fetch_fault <= 1`, `fetch_pc <= redirect_pc`, no requests issued; state `S_FAULT` (via `S_FLUSH` if outstanding). Leaves only on next redirect or reset.

## Timing
- Reset values: `imem_req` 0 during reset, `imem_addr` = `RESET_PC`, `instr_valid` 0, `instr` = 32'h0000_0013 (NOP), `instr_pc` = `RESET_PC`, `fetch_fault` 0, state `S_REQ`, queue empty.
- First cycle after reset release: `imem_req` = 1, `imem_addr` = `RESET_PC`.
- Latency: grant in cycle t, `imem_rvalid` in t+k (k≥1) → `instr_valid` in t+k+1.
- Throughput with k=1 and ready decoder: one instruction per 2 cycles.
- After redirect in cycle t: `instr_valid` = 0 in t+1; new request no earlier than t+1.
- No combinational path from `imem_gnt`, `imem_rvalid`, `instr_ready`, `redirect` to any output.
- `instr`/`instr_pc` stable while `instr_valid && !instr_ready`.
- Reset mid-transaction: outstanding response after reset is not expected; memory is reset with the core.

## Structure
- Shared package `riscuinho_pkg`: `NOP_INSTR` = 32'h0000_0013, fetch state enum, `XLEN` = 32.
- Sub-module `fetch_queue`: 2-entry FIFO of 64-bit `{pc, instr}` with `count`, push, pop, flush.

## Test plan
- Reset, memory k=1, ready always: fetches 0x0,0x4,0x8; `instr_pc` sequence 0x0,0x4,0x8, one valid every 2 cycles.
- `instr_ready` held 0: after two responses queue full, `imem_req` stays 0; release ready → pops in order, fetch resumes at 0x8.
- Redirect to 0x100 while `S_WAIT` with k=3: stale response dropped, next delivered `instr_pc` = 0x100, none from 0x4 region.
- Redirect in same cycle as `imem_gnt` and same cycle as `imem_rvalid`: no stale word ever reaches `instr_valid`.
- Redirect to 0x102: `fetch_fault` = 1, `imem_req` = 0 indefinitely; redirect to 0x200 clears fault and fetches 0x200.
- Fetch from 0xFFFF_FFFC: next request address 0x0000_0000.
